// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared defines and helpers for the multi-port register file
// Defines: SP_START_ADDR (stack-pointer reset value), ZeroWord, PEND_MAX(w)
`ifndef REGFILE_MP_DEFINES
`define REGFILE_MP_DEFINES
`define SP_START_ADDR 32'h0000_7ff0
`define ZeroWord 32'h0000_0000
`define PEND_MAX(w) ((1 << (w)) - 1)
`endif

package regfile_mp_pkg;
    // bits needed to hold a count from 0 to n
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/regfile_mp_scoreboard.sv
// regfile_mp_scoreboard: per-register pending-write counters, busy/ready logic and sb_err
// Ports: clk, rst; re/read_addr -> read_busy; iss_valid/iss_reg -> iss_ready;
//        wb_we/wb_write_reg (retires); sb_err (sticky spurious-retire flag)
module regfile_mp_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    parameter int PEND_W = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] read_addr,
    output logic [NUM_RD-1:0]        read_busy,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_reg,
    output logic                     iss_ready,
    input  logic [NUM_WR-1:0]        wb_we,
    input  logic [NUM_WR*ADDR_W-1:0] wb_write_reg,
    output logic                     sb_err
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CW = PEND_W + cnt_w(NUM_WR) + 1;
    localparam logic [CW-1:0] PMAX = CW'(`PEND_MAX(PEND_W));

    logic [PEND_W-1:0] cnt     [DEPTH];
    logic [PEND_W-1:0] cnt_nxt [DEPTH];
    logic [CW-1:0]     dec     [DEPTH];
    logic [CW-1:0]     left    [DEPTH];
    logic              issue;
    logic              spur;

    // left = counter after this cycle's retires; floored at 0 so two ports
    // retiring one outstanding write cannot wrap the counter
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            dec[r] = '0;
            for (int j = 0; j < NUM_WR; j++)
                if (wb_we[j] && wb_write_reg[j*ADDR_W +: ADDR_W] == ADDR_W'(r) && cnt[r] != '0)
                    dec[r] = dec[r] + CW'(1);
            left[r] = (dec[r] > CW'(cnt[r])) ? '0 : CW'(cnt[r]) - dec[r];
        end
    end

    assign iss_ready = !rst && (iss_reg == '0 || left[iss_reg] + CW'(1) <= PMAX);
    assign issue     = iss_valid && iss_ready && iss_reg != '0;

    always_comb begin
        for (int r = 0; r < DEPTH; r++)
            cnt_nxt[r] = PEND_W'(left[r] + CW'(issue && iss_reg == ADDR_W'(r)));
    end

    always_comb begin
        spur = 1'b0;
        for (int j = 0; j < NUM_WR; j++)
            if (wb_we[j] && wb_write_reg[j*ADDR_W +: ADDR_W] != '0 && cnt[wb_write_reg[j*ADDR_W +: ADDR_W]] == '0)
                spur = 1'b1;
    end

    // a same-cycle issue only shows up as busy from the next cycle
    always_comb begin
        read_busy = '0;
        for (int k = 0; k < NUM_RD; k++)
            read_busy[k] = !rst && re[k] && read_addr[k*ADDR_W +: ADDR_W] != '0 &&
                           left[read_addr[k*ADDR_W +: ADDR_W]] != '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++)
                cnt[r] <= '0;
            sb_err <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            sb_err <= sb_err | spur;
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write-back bypass and pending-write scoreboard
// Ports: clk, rst; re/read_addr -> read_data/read_busy (combinational);
//        iss_valid/iss_reg -> iss_ready; wb_we/wb_write_reg/wb_write_data (write-back);
//        sb_err (sticky: retire with no matching issue)
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int                 DATA_W  = 32,
    parameter int                 ADDR_W  = 5,
    parameter int                 NUM_RD  = 2,
    parameter int                 NUM_WR  = 2,
    parameter int                 SP_IDX  = 29,
    parameter logic [DATA_W-1:0]  SP_INIT = `SP_START_ADDR,
    parameter int                 PEND_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] read_addr,
    output logic [NUM_RD*DATA_W-1:0] read_data,
    output logic [NUM_RD-1:0]        read_busy,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_reg,
    output logic                     iss_ready,
    input  logic [NUM_WR-1:0]        wb_we,
    input  logic [NUM_WR*ADDR_W-1:0] wb_write_reg,
    input  logic [NUM_WR*DATA_W-1:0] wb_write_data,
    output logic                     sb_err
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];

    // ascending port loop: the last non-blocking write (highest port) wins
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++)
                regs[r] <= (r == SP_IDX) ? SP_INIT : DATA_W'(`ZeroWord);
        end else begin
            for (int j = 0; j < NUM_WR; j++)
                if (wb_we[j] && wb_write_reg[j*ADDR_W +: ADDR_W] != '0)
                    regs[wb_write_reg[j*ADDR_W +: ADDR_W]] <= wb_write_data[j*DATA_W +: DATA_W];
        end
    end

    // bypass: same-cycle write-back overrides storage, highest port last
    always_comb begin
        read_data = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (!rst && re[k] && read_addr[k*ADDR_W +: ADDR_W] != '0) begin
                read_data[k*DATA_W +: DATA_W] = regs[read_addr[k*ADDR_W +: ADDR_W]];
                for (int j = 0; j < NUM_WR; j++)
                    if (wb_we[j] && wb_write_reg[j*ADDR_W +: ADDR_W] == read_addr[k*ADDR_W +: ADDR_W])
                        read_data[k*DATA_W +: DATA_W] = wb_write_data[j*DATA_W +: DATA_W];
            end
        end
    end

    regfile_mp_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR),
        .PEND_W (PEND_W)
    ) u_sb (
        .clk          (clk),
        .rst          (rst),
        .re           (re),
        .read_addr    (read_addr),
        .read_busy    (read_busy),
        .iss_valid    (iss_valid),
        .iss_reg      (iss_reg),
        .iss_ready    (iss_ready),
        .wb_we        (wb_we),
        .wb_write_reg (wb_write_reg),
        .sb_err       (sb_err)
    );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard-driven bench for regfile_mp
module tb_regfile_mp;
    localparam logic [31:0] SP_VAL = 32'h0000_f000;
    localparam int RD0 = 0, RD1 = 1, BUSY0 = 2, BUSY1 = 3, READY = 4, ERR = 5;

    logic        clk;
    logic        rst;
    logic [1:0]  re;
    logic [9:0]  read_addr;
    logic [63:0] read_data;
    logic [1:0]  read_busy;
    logic        iss_valid;
    logic [4:0]  iss_reg;
    logic        iss_ready;
    logic [1:0]  wb_we;
    logic [9:0]  wb_write_reg;
    logic [63:0] wb_write_data;
    logic        sb_err;

    int n_cmp = 0;
    int n_bad = 0;
    string       tag_q  [$];
    int          kind_q [$];
    logic [31:0] val_q  [$];

    regfile_mp #(.SP_INIT(SP_VAL)) dut (
        .clk           (clk),
        .rst           (rst),
        .re            (re),
        .read_addr     (read_addr),
        .read_data     (read_data),
        .read_busy     (read_busy),
        .iss_valid     (iss_valid),
        .iss_reg       (iss_reg),
        .iss_ready     (iss_ready),
        .wb_we         (wb_we),
        .wb_write_reg  (wb_write_reg),
        .wb_write_data (wb_write_data),
        .sb_err        (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observed(input int kind);
        case (kind)
            RD0:     return read_data[31:0];
            RD1:     return read_data[63:32];
            BUSY0:   return {31'b0, read_busy[0]};
            BUSY1:   return {31'b0, read_busy[1]};
            READY:   return {31'b0, iss_ready};
            default: return {31'b0, sb_err};
        endcase
    endfunction

    task automatic want(input string tag, input int kind, input logic [31:0] v);
        tag_q.push_back(tag);
        kind_q.push_back(kind);
        val_q.push_back(v);
    endtask

    task automatic drain();
        while (kind_q.size() > 0)
            check(tag_q.pop_front(), observed(kind_q.pop_front()), val_q.pop_front());
    endtask

    task automatic idle();
        re = '0; read_addr = '0; iss_valid = 1'b0; iss_reg = '0;
        wb_we = '0; wb_write_reg = '0; wb_write_data = '0;
    endtask

    task automatic rd(input int k, input int a);
        re[k] = 1'b1;
        read_addr[k*5 +: 5] = 5'(a);
    endtask

    task automatic wr(input int j, input int a, input logic [31:0] d);
        wb_we[j] = 1'b1;
        wb_write_reg[j*5 +: 5] = 5'(a);
        wb_write_data[j*32 +: 32] = d;
    endtask

    task automatic iss(input int a);
        iss_valid = 1'b1;
        iss_reg = 5'(a);
    endtask

    task automatic step();
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rd(0, 29); iss(3);
        want("rst_rd0", RD0, 32'h0); want("rst_busy0", BUSY0, 0); want("rst_ready", READY, 0);
        step();
        rst = 1'b0;
        rd(0, 29); rd(1, 5);
        want("sp_init", RD0, SP_VAL); want("r5_zero", RD1, 32'h0);
        want("rst_busy0b", BUSY0, 0); want("rst_busy1b", BUSY1, 0);
        want("rst_err", ERR, 0); want("ready_idle", READY, 1);
        step();
        iss(3); rd(0, 3);
        want("iss3_ready", READY, 1); want("iss3_busy_same", BUSY0, 0);
        step();
        rd(0, 3); want("r3_busy_a", BUSY0, 1);
        step();
        rd(0, 3); want("r3_busy_b", BUSY0, 1);
        step();
        wr(0, 3, 32'habcd); rd(0, 3);
        want("r3_ret_busy", BUSY0, 0); want("r3_bypass", RD0, 32'habcd);
        step();
        rd(0, 3);
        want("r3_stored", RD0, 32'habcd); want("r3_busy_after", BUSY0, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            iss(4); want("r4_iss_ok", READY, 1);
            step();
        end
        iss(4); rd(1, 4);
        want("r4_sat", READY, 0); want("r4_busy_sat", BUSY1, 1);
        step();
        iss(4); wr(0, 4, 32'h44);
        want("r4_sat_retire", READY, 1);
        step();
        wr(0, 4, 32'h41); wr(1, 4, 32'h42); rd(0, 4);
        want("r4_dual_bypass", RD0, 32'h42); want("r4_dual_busy", BUSY0, 1);
        step();
        wr(1, 4, 32'h43); rd(0, 4);
        want("r4_last_bypass", RD0, 32'h43); want("r4_last_busy", BUSY0, 0);
        step();
        rd(0, 4);
        want("r4_stored", RD0, 32'h43); want("r4_idle_busy", BUSY0, 0); want("no_err", ERR, 0);
        step();
        wr(1, 9, 32'h99); rd(1, 9);
        want("r9_bypass", RD1, 32'h99); want("r9_err_pre", ERR, 0);
        step();
        rd(1, 9);
        want("r9_stored", RD1, 32'h99); want("r9_err", ERR, 1);
        step();
        wr(0, 7, 32'h11); wr(1, 7, 32'h22); rd(0, 7);
        want("r7_conflict_byp", RD0, 32'h22);
        step();
        rd(0, 7);
        want("r7_conflict_st", RD0, 32'h22); want("err_sticky", ERR, 1);
        step();
        wr(0, 0, 32'hdead); rd(0, 0); read_addr[9:5] = 5'd7;
        want("r0_byp", RD0, 32'h0); want("re_off", RD1, 32'h0);
        step();
        rd(0, 0);
        want("r0_st", RD0, 32'h0); want("r0_busy", BUSY0, 0);
        step();
        wr(0, 10, 32'h1010);
        step();
        iss(10); want("r10_iss", READY, 1);
        step();
        iss(11); rd(0, 10);
        want("r11_iss", READY, 1); want("r10_busy", BUSY0, 1);
        step();
        rst = 1'b1;
        rd(0, 10); rd(1, 11); wr(0, 12, 32'h12);
        want("mid_rst_rd", RD0, 32'h0); want("mid_rst_busy", BUSY0, 0);
        step();
        rst = 1'b0;
        rd(0, 10); rd(1, 11);
        want("r10_cleared", RD0, 32'h0); want("r10_busy_clr", BUSY0, 0);
        want("r11_busy_clr", BUSY1, 0); want("err_clr", ERR, 0);
        step();
        rd(0, 12); rd(1, 29);
        want("r12_not_written", RD0, 32'h0); want("sp_reinit", RD1, SP_VAL);
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
